// File: rtl/fractional_interpolator_pkg.sv
// Shared constants, types and default prototype coefficients for the 3/2 interpolator.
package fractional_interpolator_pkg;

  localparam int unsigned L = 3;
  localparam int unsigned M = 2;

  localparam int unsigned DEF_DATA_WIDTH  = 16;
  localparam int unsigned DEF_DATA_FRAC   = 15;
  localparam int unsigned DEF_COEFF_WIDTH = 20;
  localparam int unsigned DEF_COEFF_FRAC  = 18;
  localparam int unsigned DEF_N_TAP       = 72;

  // Triangular lowpass scaled so each polyphase branch has roughly unity DC gain
  localparam int unsigned DEFAULT_STEP = 590;

  typedef logic [DEF_N_TAP-1:0][DEF_COEFF_WIDTH-1:0] coeff_vec_t;

  typedef enum logic {
    ACCEPT = 1'b0,
    SECOND = 1'b1
  } state_t;

  function automatic coeff_vec_t gen_default_coeff();
    coeff_vec_t  v;
    int unsigned r;
    v = '0;
    for (int unsigned i = 0; i < DEF_N_TAP; i++) begin
      r = (i < DEF_N_TAP - 1 - i) ? i : DEF_N_TAP - 1 - i;
      v[i] = DEF_COEFF_WIDTH'((r + 1) * DEFAULT_STEP);
    end
    return v;
  endfunction

  localparam coeff_vec_t DEFAULT_COEFF = gen_default_coeff();

endpackage

// File: rtl/rounding_overflow_arith.sv
// Round-half-up, arithmetic shift and saturation of a wide accumulator to the output format.
module rounding_overflow_arith #(
  parameter int unsigned IN_WIDTH   = 41,
  parameter int unsigned OUT_WIDTH  = 16,
  parameter int unsigned FRAC_SHIFT = 18,
  parameter int unsigned SCALE      = 1
) (
  input  logic signed [IN_WIDTH-1:0]  acc,
  output logic        [OUT_WIDTH-1:0] result_c,
  output logic                        overflow_c,
  output logic                        underflow_c
);

  // SCALE is a power-of-two gain applied before rounding
  localparam int unsigned GAIN_SHIFT = $clog2(SCALE);
  localparam int unsigned EXT_WIDTH  = IN_WIDTH + GAIN_SHIFT + 1;

  localparam logic signed [EXT_WIDTH-1:0] HALF    = EXT_WIDTH'(1) << (FRAC_SHIFT - 1);
  localparam logic signed [EXT_WIDTH-1:0] SAT_MAX = EXT_WIDTH'((1 << (OUT_WIDTH - 1)) - 1);
  localparam logic signed [EXT_WIDTH-1:0] SAT_MIN = ~SAT_MAX;

  logic signed [EXT_WIDTH-1:0] scaled;
  logic signed [EXT_WIDTH-1:0] rounded;

  always_comb begin
    scaled      = EXT_WIDTH'(acc) <<< GAIN_SHIFT;
    rounded     = (scaled + HALF) >>> FRAC_SHIFT;
    overflow_c  = rounded > SAT_MAX;
    underflow_c = rounded < SAT_MIN;
    if (overflow_c) begin
      result_c = OUT_WIDTH'(SAT_MAX);
    end else if (underflow_c) begin
      result_c = OUT_WIDTH'(SAT_MIN);
    end else begin
      result_c = OUT_WIDTH'(rounded);
    end
  end

endmodule

// File: rtl/fractional_interpolator.sv
// Polyphase 3/2 sample-rate converter: one 24-tap branch evaluated per cycle,
// input throttled so at most one output sample leaves per clock.
module fractional_interpolator
  import fractional_interpolator_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int unsigned DATA_FRAC   = DEF_DATA_FRAC,
  parameter int unsigned COEFF_WIDTH = DEF_COEFF_WIDTH,
  parameter int unsigned COEFF_FRAC  = DEF_COEFF_FRAC,
  parameter int unsigned N_TAP       = DEF_N_TAP
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                valid_in,
  output logic                                in_ready,
  input  logic [DATA_WIDTH-1:0]               filter_in,
  input  logic                                coeff_wr_en,
  input  logic [N_TAP-1:0][COEFF_WIDTH-1:0]   coeff_data_in,
  output logic [DATA_WIDTH-1:0]               filter_out,
  output logic                                valid_out,
  output logic                                overflow,
  output logic                                underflow
);

  localparam int unsigned PHASE_N_TAP = N_TAP / L;
  localparam int unsigned PROD_WIDTH  = DATA_WIDTH + COEFF_WIDTH;
  localparam int unsigned PROD_FRAC   = DATA_FRAC + COEFF_FRAC;
  localparam int unsigned ACC_WIDTH   = PROD_WIDTH + $clog2(PHASE_N_TAP);

  state_t state, state_next;
  logic   parity;
  logic   accept_c, emit_c;
  logic [1:0] phase_c;

  logic signed [COEFF_WIDTH-1:0] coeff [N_TAP];
  logic signed [DATA_WIDTH-1:0]  dly   [PHASE_N_TAP];
  logic signed [DATA_WIDTH-1:0]  win_c [PHASE_N_TAP];
  logic signed [ACC_WIDTH-1:0]   acc_c;
  logic [DATA_WIDTH-1:0]         sat_c;
  logic                          ovf_c, unf_c;

  assign in_ready = (state == ACCEPT) && !rst && !coeff_wr_en;

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ACCEPT;
    end else begin
      state <= state_next;
    end
  end

  // Next state and emit decision; even inputs need a second (phase-2) cycle
  always_comb begin
    state_next = state;
    accept_c   = 1'b0;
    emit_c     = 1'b0;
    phase_c    = 2'd0;
    unique case (state)
      ACCEPT: begin
        accept_c = valid_in && in_ready;
        emit_c   = accept_c;
        phase_c  = {1'b0, parity};
        if (accept_c && !parity) begin
          state_next = SECOND;
        end
      end
      SECOND: begin
        emit_c     = !coeff_wr_en;
        phase_c    = 2'd2;
        state_next = ACCEPT;
      end
      default: state_next = ACCEPT;
    endcase
    if (coeff_wr_en) begin
      state_next = ACCEPT;
    end
  end

  // In ACCEPT the MAC sees the line as it will be after the incoming sample shifts in
  always_comb begin
    logic signed [COEFF_WIDTH-1:0] coef;
    logic signed [PROD_WIDTH-1:0]  prod;
    acc_c    = '0;
    coef     = '0;
    prod     = '0;
    win_c[0] = (state == ACCEPT) ? $signed(filter_in) : dly[0];
    for (int unsigned j = 1; j < PHASE_N_TAP; j++) begin
      win_c[j] = (state == ACCEPT) ? dly[j-1] : dly[j];
    end
    for (int unsigned j = 0; j < PHASE_N_TAP; j++) begin
      if (phase_c == 2'd0) begin
        coef = coeff[L*j];
      end else if (phase_c == 2'd1) begin
        coef = coeff[L*j + 1];
      end else begin
        coef = coeff[L*j + 2];
      end
      prod  = PROD_WIDTH'(win_c[j]) * PROD_WIDTH'(coef);
      acc_c = acc_c + ACC_WIDTH'(prod);
    end
  end

  rounding_overflow_arith #(
    .IN_WIDTH  (ACC_WIDTH),
    .OUT_WIDTH (DATA_WIDTH),
    .FRAC_SHIFT(PROD_FRAC - DATA_FRAC),
    .SCALE     (1)
  ) u_round (
    .acc        (acc_c),
    .result_c   (sat_c),
    .overflow_c (ovf_c),
    .underflow_c(unf_c)
  );

  // Coefficients, delay line, parity and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      parity     <= 1'b0;
      filter_out <= '0;
      valid_out  <= 1'b0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
      for (int unsigned i = 0; i < PHASE_N_TAP; i++) dly[i] <= '0;
      for (int unsigned i = 0; i < N_TAP; i++) coeff[i] <= COEFF_WIDTH'(DEFAULT_COEFF[i]);
    end else begin
      if (coeff_wr_en) begin
        parity <= 1'b0;
        for (int unsigned i = 0; i < PHASE_N_TAP; i++) dly[i] <= '0;
        for (int unsigned i = 0; i < N_TAP; i++) coeff[i] <= coeff_data_in[i];
      end else if (accept_c) begin
        parity <= ~parity;
        dly[0] <= $signed(filter_in);
        for (int unsigned i = 1; i < PHASE_N_TAP; i++) dly[i] <= dly[i-1];
      end
      valid_out <= emit_c;
      overflow  <= emit_c && ovf_c;
      underflow <= emit_c && unf_c;
      if (emit_c) begin
        filter_out <= sat_c;
      end
    end
  end

endmodule

// File: tb/tb_fractional_interpolator.sv
// Randomized bench for the 3/2 interpolator against a direct upsample-filter-decimate model.
module tb_fractional_interpolator;

  localparam int NT = 72;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 valid_in;
  logic                 in_ready;
  logic [15:0]          filter_in;
  logic                 coeff_wr_en;
  logic [NT-1:0][19:0]  coeff_bus;
  logic [15:0]          filter_out;
  logic                 valid_out;
  logic                 overflow;
  logic                 underflow;

  always #5 clk = ~clk;

  fractional_interpolator dut (
    .clk          (clk),
    .rst          (rst),
    .valid_in     (valid_in),
    .in_ready     (in_ready),
    .filter_in    (filter_in),
    .coeff_wr_en  (coeff_wr_en),
    .coeff_data_in(coeff_bus),
    .filter_out   (filter_out),
    .valid_out    (valid_out),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  // Reference state: accepted input history, active coefficients, next output index
  int hist[$];
  int obs[$];
  int mc[NT];
  int next_k;
  bit carry_v;
  int carry_y;
  bit carry_ov, carry_un;
  int last_y;
  int n_checks, n_pass;

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got == exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // y[k] = sum_i c[i] * v[2k-i], v[m] = x[m/3] when 3 divides m, else 0
  function automatic void gen_out(input int k, output int y, output bit ov, output bit un);
    longint acc;
    int     m;
    acc = 0;
    m   = 2 * k;
    for (int i = 0; i < NT; i++) begin
      if (m - i >= 0 && (m - i) % 3 == 0) begin
        acc += longint'(mc[i]) * longint'(hist[(m - i) / 3]);
      end
    end
    acc = (acc + 131072) >>> 18;
    ov  = acc > 32767;
    un  = acc < -32768;
    y   = ov ? 32767 : (un ? -32768 : int'(acc));
  endfunction

  task automatic reset_model();
    int r;
    hist.delete();
    next_k  = 0;
    carry_v = 1'b0;
    for (int i = 0; i < NT; i++) begin
      r = (i < NT - 1 - i) ? i : NT - 1 - i;
      mc[i] = (r + 1) * 590;
    end
  endtask

  task automatic tick(input bit v, input int x, input bit cw, input bit r);
    bit mready;
    bit e_v, e_ov, e_un;
    int e_y;
    valid_in    = v;
    filter_in   = 16'(x);
    coeff_wr_en = cw;
    rst         = r;
    #1;
    mready = !carry_v && !r && !cw;
    check("in_ready", in_ready, mready);
    e_v = 1'b0; e_ov = 1'b0; e_un = 1'b0; e_y = 0;
    if (r) begin
      reset_model();
      last_y = 0;
    end else if (cw) begin
      hist.delete();
      next_k  = 0;
      carry_v = 1'b0;
      for (int i = 0; i < NT; i++) mc[i] = int'($signed(coeff_bus[i]));
    end else if (carry_v) begin
      e_v = 1'b1; e_y = carry_y; e_ov = carry_ov; e_un = carry_un;
      carry_v = 1'b0;
    end else if (v && mready) begin
      hist.push_back(x);
      gen_out(next_k, e_y, e_ov, e_un);
      e_v = 1'b1;
      next_k++;
      if ((2 * next_k) / 3 == hist.size() - 1) begin
        gen_out(next_k, carry_y, carry_ov, carry_un);
        carry_v = 1'b1;
        next_k++;
      end
    end
    @(posedge clk);
    #1;
    if (e_v) last_y = e_y;
    check("valid_out", valid_out, e_v);
    check("filter_out", longint'($signed(filter_out)), last_y);
    check("overflow", overflow, e_ov);
    check("underflow", underflow, e_un);
    if (valid_out) obs.push_back(int'($signed(filter_out)));
  endtask

  // Hold valid_in high until the sample is taken (at most one stall cycle)
  task automatic send(input int x);
    bit rdy;
    for (int t = 0; t < 4; t++) begin
      rdy = !carry_v;
      tick(1'b1, x, 1'b0, 1'b0);
      if (rdy) return;
    end
  endtask

  task automatic load_coeffs();
    tick(1'b0, 0, 1'b1, 1'b0);
  endtask

  task automatic random_coeffs();
    for (int i = 0; i < NT; i++) coeff_bus[i] = 20'(int'($urandom_range(0, 16383)) - 8192);
  endtask

  initial begin
    n_checks = 0; n_pass = 0; last_y = 0;
    coeff_bus = '0; valid_in = 1'b0; filter_in = '0; coeff_wr_en = 1'b0; rst = 1'b1;
    reset_model();
    tick(1'b0, 0, 1'b0, 1'b1);
    tick(1'b0, 0, 1'b0, 1'b1);

    // Phase-0 impulse
    coeff_bus = '0; coeff_bus[0] = 20'h40000;
    load_coeffs();
    obs.delete();
    send(16'h4000);
    repeat (10) tick(1'b1, 0, 1'b0, 1'b0);
    check("imp0_first", obs[0], 16384);
    check("imp0_second", obs[1], 0);

    // Phase-1 impulse
    coeff_bus = '0; coeff_bus[4] = 20'h40000;
    load_coeffs();
    obs.delete();
    send(16'h4000);
    repeat (10) tick(1'b1, 0, 1'b0, 1'b0);
    check("imp1_k0", obs[0], 0);
    check("imp1_k2", obs[2], 16384);

    // Throughput with default coefficients, valid_in held high
    tick(1'b0, 0, 1'b0, 1'b1);
    obs.delete();
    for (int s = 1; s <= 12; s++) send(s);
    repeat (4) tick(1'b0, 0, 1'b0, 1'b0);
    check("ramp_pulses", obs.size(), 18);

    // Saturation, positive then negative
    for (int i = 0; i < NT; i++) coeff_bus[i] = 20'h7FFFF;
    load_coeffs();
    repeat (30) send(32767);
    check("sat_pos", longint'($signed(filter_out)), 32767);
    repeat (30) send(-32768);
    check("sat_neg", longint'($signed(filter_out)), -32768);
    repeat (3) tick(1'b0, 0, 1'b0, 1'b0);

    // Coefficient write while a phase-2 output is pending
    random_coeffs();
    load_coeffs();
    for (int i = 0; i < 5; i++) send(int'($signed(16'($urandom))));
    for (int t = 0; t < 3 && !carry_v; t++) send(int'($signed(16'($urandom))));
    coeff_bus = '0; coeff_bus[0] = 20'h20000; coeff_bus[2] = 20'h10000;
    tick(1'b1, 1234, 1'b1, 1'b0);
    obs.delete();
    send(16'h4000);
    repeat (4) tick(1'b0, 0, 1'b0, 1'b0);
    check("cw_phase0", obs[0], 8192);
    check("cw_phase2", obs[1], 4096);

    // Reset while a phase-2 output is pending, then default impulse response
    random_coeffs();
    load_coeffs();
    for (int t = 0; t < 3 && !carry_v; t++) send(int'($signed(16'($urandom))));
    tick(1'b1, 555, 1'b0, 1'b1);
    tick(1'b0, 0, 1'b0, 1'b0);
    obs.delete();
    send(16'h4000);
    repeat (8) tick(1'b0, 0, 1'b0, 1'b0);
    check("rst_def_k0", obs[0], 37);
    check("rst_def_k1", obs[1], 111);

    // Random traffic with occasional coefficient reloads
    random_coeffs();
    load_coeffs();
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 99) == 0) begin
        random_coeffs();
        tick(($urandom % 2) == 1, 0, 1'b1, 1'b0);
      end else begin
        tick(($urandom % 10) < 7, int'($signed(16'($urandom))), 1'b0, 1'b0);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
